// File: rtl/audio_divider_pair_if.sv
// Bus bundle for the audio divider pair: CPU write port, mode/timing
// controls, and the divider state/pulse outputs.
interface audio_divider_pair_if;
  logic       enp;
  logic       base_tick;
  logic       fast_lo;
  logic       link;
  logic       stimer;
  logic       wr_lo;
  logic       wr_hi;
  logic [7:0] din;
  logic [7:0] audf_lo;
  logic [7:0] audf_hi;
  logic [7:0] cnt_lo;
  logic [7:0] cnt_hi;
  logic       pulse_lo;
  logic       pulse_hi;

  modport master (
    output enp, base_tick, fast_lo, link, stimer, wr_lo, wr_hi, din,
    input  audf_lo, audf_hi, cnt_lo, cnt_hi, pulse_lo, pulse_hi
  );

  modport slave (
    input  enp, base_tick, fast_lo, link, stimer, wr_lo, wr_hi, din,
    output audf_lo, audf_hi, cnt_lo, cnt_hi, pulse_lo, pulse_hi
  );
endinterface

// File: rtl/audio_divider_pair.sv
// Pair of 8-bit AUDF frequency dividers with an optional 16-bit linked mode;
// produces one-clk divider pulses for the downstream audio channel stages.
module audio_divider_pair #(
  parameter int HOLD_FAST      = 3,
  parameter int HOLD_LINK_FAST = 6
) (
  input logic                 clk,
  input logic                 reset,
  audio_divider_pair_if.slave bus
);

  localparam logic [7:0] HOLD_FAST_V = 8'(HOLD_FAST);
  localparam logic [7:0] HOLD_LINK_V = 8'(HOLD_LINK_FAST);

  typedef enum logic {ST_COUNT = 1'b0, ST_HOLD = 1'b1} state_e;

  typedef struct packed {
    state_e     st;
    logic [7:0] hold;
    logic       fire;
    logic       clr;
    logic       inc;
  } step_t;

  // One enp-qualified step of a channel FSM; the caller applies clr/inc to its counter.
  function automatic step_t fsm_step(input state_e st, input logic [7:0] hold,
                                     input logic tick, input logic hit,
                                     input logic fast, input logic [7:0] hold_len);
    step_t r;
    r = '{st: st, hold: hold, fire: 1'b0, clr: 1'b0, inc: 1'b0};
    case (st)
      ST_COUNT: begin
        if (tick && hit) begin
          r.clr = 1'b1;
          if (fast) begin
            r.st   = ST_HOLD;
            r.hold = hold_len;
          end else begin
            r.fire = 1'b1;
          end
        end else if (tick) begin
          r.inc = 1'b1;
        end else begin
          r.inc = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hold <= 8'd1) begin
          r.st   = ST_COUNT;
          r.hold = 8'd0;
          r.fire = 1'b1;
        end else begin
          r.hold = hold - 8'd1;
        end
      end
      default: begin
        r.st   = ST_COUNT;
        r.hold = 8'd0;
      end
    endcase
    return r;
  endfunction

  state_e     st_lo_q, st_lo_d, st_hi_q, st_hi_d;
  logic [7:0] audf_lo_q, audf_lo_d, audf_hi_q, audf_hi_d;
  logic [7:0] cnt_lo_q, cnt_lo_d, cnt_hi_q, cnt_hi_d;
  logic [7:0] hold_lo_q, hold_lo_d, hold_hi_q, hold_hi_d;
  logic       pulse_lo_q, pulse_lo_d, pulse_hi_q, pulse_hi_d;
  logic       tick_lo, tick_hi;
  logic [15:0] cnt16_inc;
  step_t      s_lo, s_hi, s_pair;

  // Next-state logic; in linked mode the high channel FSM runs the 16-bit pair.
  always_comb begin
    tick_lo   = bus.enp & (bus.fast_lo | bus.base_tick);
    tick_hi   = bus.enp & bus.base_tick;
    s_lo      = fsm_step(st_lo_q, hold_lo_q, tick_lo, cnt_lo_q == audf_lo_q,
                         bus.fast_lo, HOLD_FAST_V);
    s_hi      = fsm_step(st_hi_q, hold_hi_q, tick_hi, cnt_hi_q == audf_hi_q,
                         1'b0, HOLD_FAST_V);
    s_pair    = fsm_step(st_hi_q, hold_hi_q, tick_lo,
                         {cnt_hi_q, cnt_lo_q} == {audf_hi_q, audf_lo_q},
                         bus.fast_lo, HOLD_LINK_V);
    cnt16_inc = {cnt_hi_q, cnt_lo_q} + 16'd1;

    st_lo_d    = st_lo_q;
    st_hi_d    = st_hi_q;
    cnt_lo_d   = cnt_lo_q;
    cnt_hi_d   = cnt_hi_q;
    hold_lo_d  = hold_lo_q;
    hold_hi_d  = hold_hi_q;
    pulse_lo_d = 1'b0;
    pulse_hi_d = 1'b0;

    if (bus.enp && bus.wr_lo) begin
      audf_lo_d = bus.din;
    end else begin
      audf_lo_d = audf_lo_q;
    end
    if (bus.enp && bus.wr_hi) begin
      audf_hi_d = bus.din;
    end else begin
      audf_hi_d = audf_hi_q;
    end

    if (!bus.enp) begin
      st_lo_d = st_lo_q;
    end else if (bus.stimer) begin
      st_lo_d   = ST_COUNT;
      st_hi_d   = ST_COUNT;
      cnt_lo_d  = 8'd0;
      cnt_hi_d  = 8'd0;
      hold_lo_d = 8'd0;
      hold_hi_d = 8'd0;
    end else if (bus.link) begin
      st_hi_d    = s_pair.st;
      hold_hi_d  = s_pair.hold;
      pulse_hi_d = s_pair.fire;
      if (s_pair.clr) begin
        cnt_lo_d = 8'd0;
        cnt_hi_d = 8'd0;
      end else if (s_pair.inc) begin
        {cnt_hi_d, cnt_lo_d} = cnt16_inc;
      end else begin
        cnt_lo_d = cnt_lo_q;
      end
    end else begin
      st_lo_d    = s_lo.st;
      hold_lo_d  = s_lo.hold;
      pulse_lo_d = s_lo.fire;
      if (s_lo.clr) begin
        cnt_lo_d = 8'd0;
      end else if (s_lo.inc) begin
        cnt_lo_d = cnt_lo_q + 8'd1;
      end else begin
        cnt_lo_d = cnt_lo_q;
      end
      st_hi_d    = s_hi.st;
      hold_hi_d  = s_hi.hold;
      pulse_hi_d = s_hi.fire;
      if (s_hi.clr) begin
        cnt_hi_d = 8'd0;
      end else if (s_hi.inc) begin
        cnt_hi_d = cnt_hi_q + 8'd1;
      end else begin
        cnt_hi_d = cnt_hi_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_lo_q    <= ST_COUNT;
      st_hi_q    <= ST_COUNT;
      audf_lo_q  <= 8'd0;
      audf_hi_q  <= 8'd0;
      cnt_lo_q   <= 8'd0;
      cnt_hi_q   <= 8'd0;
      hold_lo_q  <= 8'd0;
      hold_hi_q  <= 8'd0;
      pulse_lo_q <= 1'b0;
      pulse_hi_q <= 1'b0;
    end else begin
      st_lo_q    <= st_lo_d;
      st_hi_q    <= st_hi_d;
      audf_lo_q  <= audf_lo_d;
      audf_hi_q  <= audf_hi_d;
      cnt_lo_q   <= cnt_lo_d;
      cnt_hi_q   <= cnt_hi_d;
      hold_lo_q  <= hold_lo_d;
      hold_hi_q  <= hold_hi_d;
      pulse_lo_q <= pulse_lo_d;
      pulse_hi_q <= pulse_hi_d;
    end
  end

  assign bus.audf_lo  = audf_lo_q;
  assign bus.audf_hi  = audf_hi_q;
  assign bus.cnt_lo   = cnt_lo_q;
  assign bus.cnt_hi   = cnt_hi_q;
  assign bus.pulse_lo = pulse_lo_q;
  assign bus.pulse_hi = pulse_hi_q;

endmodule

// File: tb/tb_audio_divider_pair.sv
// Self-checking bench for audio_divider_pair: directed vector table, period
// sequences, and randomized traffic against an integer reference model.
module tb_audio_divider_pair;
  localparam int HF  = 3;
  localparam int HLF = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_divider_pair_if bus();

  audio_divider_pair #(.HOLD_FAST(HF), .HOLD_LINK_FAST(HLF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst, enp, bt, fast, link, stim, wl, wh;
    logic [7:0] din;
    logic [7:0] alo, ahi, clo, chi;
    logic       plo, phi;
  } vec_t;

  vec_t tbl[18];
  int n_vec = 0;
  int n_mis = 0;

  int m_audf_lo, m_audf_hi, m_cnt_lo, m_cnt_hi, m_hold_lo, m_hold_pair;
  int m_p_lo, m_p_hi;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, hold tracked as remaining enp cycles.
  task automatic model_step();
    int na_lo, na_hi, n, c;
    m_p_lo = 0;
    m_p_hi = 0;
    if (reset) begin
      m_audf_lo = 0; m_audf_hi = 0; m_cnt_lo = 0; m_cnt_hi = 0;
      m_hold_lo = 0; m_hold_pair = 0;
    end else if (bus.enp) begin
      na_lo = bus.wr_lo ? int'(bus.din) : m_audf_lo;
      na_hi = bus.wr_hi ? int'(bus.din) : m_audf_hi;
      if (bus.stimer) begin
        m_cnt_lo = 0; m_cnt_hi = 0; m_hold_lo = 0; m_hold_pair = 0;
      end else if (bus.link) begin
        n = m_audf_hi * 256 + m_audf_lo;
        c = m_cnt_hi * 256 + m_cnt_lo;
        if (m_hold_pair > 0) begin
          m_hold_pair--;
          if (m_hold_pair == 0) m_p_hi = 1;
        end else if (bus.fast_lo || bus.base_tick) begin
          if (c == n) begin
            c = 0;
            if (bus.fast_lo) m_hold_pair = HLF;
            else m_p_hi = 1;
          end else begin
            c = (c + 1) % 65536;
          end
        end
        m_cnt_hi = c / 256;
        m_cnt_lo = c % 256;
      end else begin
        if (m_hold_lo > 0) begin
          m_hold_lo--;
          if (m_hold_lo == 0) m_p_lo = 1;
        end else if (bus.fast_lo || bus.base_tick) begin
          if (m_cnt_lo == m_audf_lo) begin
            m_cnt_lo = 0;
            if (bus.fast_lo) m_hold_lo = HF;
            else m_p_lo = 1;
          end else begin
            m_cnt_lo = (m_cnt_lo + 1) % 256;
          end
        end
        if (bus.base_tick) begin
          if (m_cnt_hi == m_audf_hi) begin
            m_cnt_hi = 0;
            m_p_hi = 1;
          end else begin
            m_cnt_hi = (m_cnt_hi + 1) % 256;
          end
        end
      end
      m_audf_lo = na_lo;
      m_audf_hi = na_hi;
    end
  endtask

  task automatic check_model();
    chk("audf_lo", 16'(bus.audf_lo), 16'(m_audf_lo));
    chk("audf_hi", 16'(bus.audf_hi), 16'(m_audf_hi));
    chk("cnt_lo", 16'(bus.cnt_lo), 16'(m_cnt_lo));
    chk("cnt_hi", 16'(bus.cnt_hi), 16'(m_cnt_hi));
    chk("pulse_lo", 16'(bus.pulse_lo), 16'(m_p_lo));
    chk("pulse_hi", 16'(bus.pulse_hi), 16'(m_p_hi));
  endtask

  task automatic cycle(input bit use_model);
    model_step();
    @(posedge clk);
    #1;
    if (use_model) check_model();
  endtask

  task automatic idle();
    reset = 1'b0; bus.enp = 1'b1; bus.base_tick = 1'b0; bus.fast_lo = 1'b0;
    bus.link = 1'b0; bus.stimer = 1'b0; bus.wr_lo = 1'b0; bus.wr_hi = 1'b0;
    bus.din = 8'h00;
  endtask

  // Runs with enp=1 until two pulses on the chosen channel; period in clk, -1 if none.
  task automatic run_period(input bit hi, input int every, input int limit,
                            output int period, output int lo_seen);
    int first;
    first = -1; period = -1; lo_seen = 0;
    for (int t = 0; t < limit; t++) begin
      bus.base_tick = ((t % every) == 0);
      cycle(1'b1);
      if (bus.pulse_lo) lo_seen++;
      if ((hi ? bus.pulse_hi : bus.pulse_lo) == 1'b1) begin
        if (first < 0) begin
          first = t;
        end else begin
          period = t - first;
          break;
        end
      end
    end
  endtask

  initial begin
    int p, lo_seen, n;
    bit found;
    idle();
    reset = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      bus.enp       = ($urandom_range(0, 3) != 0);
      bus.base_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) bus.fast_lo = ~bus.fast_lo;
      bus.wr_lo  = ($urandom_range(0, 24) == 0);
      bus.wr_hi  = ($urandom_range(0, 24) == 0);
      bus.din    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      bus.stimer = ($urandom_range(0, 59) == 0);
      reset      = ($urandom_range(0, 799) == 0);
      if ((bus.stimer && bus.enp) || reset) bus.link = 1'($urandom_range(0, 1));
      cycle(1'b1);
    end

    //            rst   enp   bt    fast  link  stim  wl    wh    din    alo    ahi    clo    chi    plo   phi
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 8'h05, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 8'h00, 8'h02, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'h00, 8'h03, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 8'h01, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h01, 8'h01, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h00, 8'h01, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h00, 8'h01, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h07, 8'h01, 8'h01, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; bus.enp = tbl[i].enp; bus.base_tick = tbl[i].bt;
      bus.fast_lo = tbl[i].fast; bus.link = tbl[i].link; bus.stimer = tbl[i].stim;
      bus.wr_lo = tbl[i].wl; bus.wr_hi = tbl[i].wh; bus.din = tbl[i].din;
      cycle(1'b0);
      chk($sformatf("row%0d_audf_lo", i), 16'(bus.audf_lo), 16'(tbl[i].alo));
      chk($sformatf("row%0d_audf_hi", i), 16'(bus.audf_hi), 16'(tbl[i].ahi));
      chk($sformatf("row%0d_cnt_lo", i), 16'(bus.cnt_lo), 16'(tbl[i].clo));
      chk($sformatf("row%0d_cnt_hi", i), 16'(bus.cnt_hi), 16'(tbl[i].chi));
      chk($sformatf("row%0d_pulse_lo", i), 16'(bus.pulse_lo), 16'(tbl[i].plo));
      chk($sformatf("row%0d_pulse_hi", i), 16'(bus.pulse_hi), 16'(tbl[i].phi));
    end

    idle();
    bus.stimer = 1'b1; bus.wr_lo = 1'b1; bus.din = 8'h03;
    cycle(1'b1);
    idle();
    run_period(1'b0, 2, 60, p, lo_seen);
    chk("slow_period_audf3", 16'(p), 16'd8);

    idle();
    bus.stimer = 1'b1; bus.wr_lo = 1'b1; bus.din = 8'h02; bus.fast_lo = 1'b1;
    cycle(1'b1);
    bus.stimer = 1'b0; bus.wr_lo = 1'b0;
    run_period(1'b0, 1, 60, p, lo_seen);
    chk("fast_period_audf2", 16'(p), 16'd6);

    bus.wr_lo = 1'b1; bus.din = 8'h00; bus.stimer = 1'b1;
    cycle(1'b1);
    bus.stimer = 1'b0; bus.wr_lo = 1'b0;
    run_period(1'b0, 1, 60, p, lo_seen);
    chk("fast_period_audf0", 16'(p), 16'd4);

    idle();
    bus.link = 1'b1; bus.stimer = 1'b1; bus.wr_hi = 1'b1; bus.din = 8'h01;
    cycle(1'b1);
    bus.stimer = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.din = 8'h02;
    cycle(1'b1);
    bus.wr_lo = 1'b0;
    run_period(1'b1, 1, 800, p, lo_seen);
    chk("link_slow_period", 16'(p), 16'd259);
    chk("link_slow_lo_quiet", 16'(lo_seen), 16'd0);
    bus.fast_lo = 1'b1;
    run_period(1'b1, 1, 800, p, lo_seen);
    chk("link_fast_period", 16'(p), 16'd265);
    chk("link_fast_lo_quiet", 16'(lo_seen), 16'd0);

    idle();
    bus.stimer = 1'b1; bus.wr_lo = 1'b1; bus.din = 8'h03;
    cycle(1'b1);
    idle();
    bus.base_tick = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b1);
    chk("stimer_pre_cnt", 16'(bus.cnt_lo), 16'd3);
    bus.stimer = 1'b1;
    cycle(1'b1);
    bus.stimer = 1'b0;
    chk("stimer_no_pulse", 16'(bus.pulse_lo), 16'd0);
    chk("stimer_cnt_zero", 16'(bus.cnt_lo), 16'd0);
    found = 1'b0; n = 1;
    for (int t = 0; t < 20; t++) begin
      cycle(1'b1);
      if (bus.pulse_lo) begin found = 1'b1; break; end
      n++;
    end
    chk("stimer_next_ticks", found ? 16'(n) : 16'hFFFF, 16'd4);

    idle();
    bus.stimer = 1'b1; bus.wr_lo = 1'b1; bus.din = 8'h10;
    cycle(1'b1);
    idle();
    bus.base_tick = 1'b1;
    for (int k = 0; k < 8; k++) cycle(1'b1);
    chk("wrap_start_cnt", 16'(bus.cnt_lo), 16'h08);
    bus.base_tick = 1'b0; bus.wr_lo = 1'b1; bus.din = 8'h02;
    cycle(1'b1);
    bus.wr_lo = 1'b0;
    chk("wrap_cnt_kept", 16'(bus.cnt_lo), 16'h08);
    found = 1'b0; n = 0;
    bus.base_tick = 1'b1;
    for (int t = 0; t < 400; t++) begin
      cycle(1'b1);
      if (bus.pulse_lo) begin found = 1'b1; break; end
      n++;
    end
    chk("wrap_ticks", found ? 16'(n) : 16'hFFFF, 16'd250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/audio_divider_pair.md
# audio_divider_pair

Two 8-bit audio frequency dividers (channel pair) with an optional 16-bit linked mode, directly upstream of the channel output/polynomial-gating stage. Each channel holds a CPU-written AUDF value, counts enabled base-clock ticks, and on reaching AUDF emits a one-`clk` divider pulse and restarts. The block consumes the chip phase enable `enp` and a selected base tick, and produces the per-channel clock-enable pulses that the downstream audio stages consume.

## Interface
- `HOLD_FAST`, 3, extra `enp` cycles inserted after a match in 8-bit fast mode.
- `HOLD_LINK_FAST`, 6, extra `enp` cycles inserted after a match in linked fast mode.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enp`  in  1  phase enable; no state changes when 0.
- `base_tick`  in  1  selected base clock tick (64 kHz/15 kHz); qualified by `enp`.
- `fast_lo`  in  1  low channel (linked: whole pair) counts every `enp` cycle.
- `link`  in  1  1 = 16-bit mode, `{audf_hi,audf_lo}`.
- `stimer`  in  1  restart both counters.
- `wr_lo`, `wr_hi`  in  1  AUDF write strobes, sampled only when `enp`=1.
- `din`  in  8  write data.
- `audf_lo`, `audf_hi`  out  8  stored AUDF values.
- `cnt_lo`, `cnt_hi`  out  8  current counts.
- `pulse_lo`, `pulse_hi`  out  1  divider output pulses, one `clk` wide.

## Operation
- Reset: `audf_*`=0, `cnt_*`=0, `pulse_*`=0, both channel FSMs in COUNT, hold counters 0.
- Tick: low channel ticks on `enp & (fast_lo | base_tick)`; high channel (unlinked) on `enp & base_tick`.
- Per-channel FSM, states COUNT and HOLD:
  - COUNT, tick, `cnt != audf`: `cnt <= cnt+1`, 8-bit, no saturation.
  - COUNT, tick, `cnt == audf`: `cnt <= 0` and match.
    - Match with the channel not fast: fire the pulse and stay in COUNT.
    - Match with fast: load hold counter with `HOLD_FAST` and go to HOLD.
  - HOLD: each `enp` cycle decrements the hold counter and ignores ticks. At 0, fire the pulse and return to COUNT.
- Resulting periods:
  - Slow: `audf+1` ticks.
  - Fast: `audf+1+HOLD_FAST` = `audf+4` `enp` cycles.
- Linked (`link`=1):
  - Pair acts as one 16-bit counter `{cnt_hi,cnt_lo}` against `{audf_hi,audf_lo}`, using the low tick source.
  - Carry from `cnt_lo`=FF to `cnt_hi`.
  - Fast hold length is `HOLD_LINK_FAST` (period N+7).
  - Match fires `pulse_hi` only; `pulse_lo` is held 0.
- Writes: when `enp` and `wr_*`, the AUDF register loads `din`. The count is not disturbed.
- `stimer` (with `enp`): both `cnt_*` <= 0, FSMs to COUNT, hold cleared, no pulse this cycle. Writes in the same cycle still take effect.
- Changing `link` or `fast_lo` mid-count is allowed. The new mode applies from the next `enp` cycle, and counts are kept.

## Timing
- Compare uses the registered AUDF, so a write coincident with a match uses the old value. The new value applies from the next `enp` cycle.
- Pulse latency: `pulse_*` is registered and high for exactly the one `clk` following the `enp` edge on which the match (slow) or hold expiry (fast) occurred. It is low otherwise, including when `enp`=0 on the next cycle.
- Priority: `reset` > `stimer` > match/HOLD > increment.
- `audf`=0:
  - Slow: a pulse every tick.
  - Fast: a pulse every 4 `enp` cycles.
- `cnt > audf` after a write lowers AUDF: the count runs up, wraps FF->00, then matches. There is no early compare.
- `reset` mid-HOLD or mid-pulse: outputs return to reset values on the next edge, and no pulse is emitted.

## Test plan
- Reset/write:
  - Assert `reset` with `enp`=1 and random state -> all outputs 0 next cycle.
  - Write `audf_lo`=0x05 -> `audf_lo`=0x05 one cycle later, `cnt_lo` unchanged.
- Slow divide: `audf_lo`=3, `base_tick` every 2nd `enp` cycle, `enp` constant -> `pulse_lo` every 8 `clk`, 1 `clk` wide, `cnt_lo` sequence 0,1,2,3,0.
- Fast hold: `fast_lo`=1, `audf_lo`=2, `enp`=1 -> `pulse_lo` period 6 `clk`. With `audf_lo`=0, period 4.
- Linked:
  - `link`=1, `audf_hi`=0x01, `audf_lo`=0x02, slow with `base_tick` every `enp` -> `pulse_hi` period 259, `pulse_lo` never.
  - Same values with fast -> period 265.
- `stimer` collision: `stimer` on the cycle `cnt_lo`==`audf_lo` with a tick -> no pulse, `cnt_lo`=0. Next pulse after a full `audf+1` ticks.
- Write collision: write `audf_lo` 3->1 on the matching cycle -> pulse fires (old value), next period 2 ticks. Write 0x10->0x02 while `cnt_lo`=0x08 -> count wraps through FF, pulse at `cnt_lo`=0x02 after 250 ticks.
